// File: rtl/mem_load_queue_if.sv
// Handshake bundle for the load queue: request/issue, memory response and writeback.
interface mem_load_queue_if #(parameter int TAG_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_op;
  logic [31:0]      req_addr;
  logic [TAG_W-1:0] req_tag;
  logic             req_rf_wr;
  logic             req_adel;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [31:0]      mem_req_addr;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_data;
  logic             flush;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic [3:0]       wb_we;
  logic [31:0]      wb_data;

  modport master (
    output req_valid, req_op, req_addr, req_tag, req_rf_wr, mem_req_ready,
           mem_resp_valid, mem_resp_data, flush, wb_ready,
    input  req_ready, req_adel, mem_req_valid, mem_req_addr, wb_valid, wb_tag, wb_we, wb_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_tag, req_rf_wr, mem_req_ready,
           mem_resp_valid, mem_resp_data, flush, wb_ready,
    output req_ready, req_adel, mem_req_valid, mem_req_addr, wb_valid, wb_tag, wb_we, wb_data
  );
endinterface

// File: rtl/mem_load_queue.sv
// In-order load queue: issues word-aligned reads, tracks DEPTH outstanding loads and
// aligns/extends each returned word into a register writeback with byte enables.
module mem_load_queue #(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 5,
  parameter int BIG_ENDIAN = 0
) (
  input  logic            clk,
  input  logic            rst,
  mem_load_queue_if.slave lq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0]    LANE_X  = (BIG_ENDIAN != 0) ? 2'b11 : 2'b00;
  localparam int OP_LB = 0, OP_LBU = 1, OP_LH = 2, OP_LHU = 3, OP_LW = 4, OP_LWL = 5, OP_LWR = 6;

  logic [6:0]       op_q   [DEPTH];
  logic [1:0]       off_q  [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] rfwr_q, dvalid_q, kill_q;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d;
  logic             misalign, space, enq, ret, head_live;

  // Returns {we, data} for one load given its byte lane and the raw memory word.
  function automatic logic [35:0] align_word(input logic [6:0] op, input logic [1:0] lane,
                                             input logic rf_wr, input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    logic [3:0]         we;
    b  = d[{lane, 3'b000} +: 8];
    h  = lane[1] ? d[31:16] : d[15:0];
    r  = d;
    we = rf_wr ? 4'hF : 4'h0;
    if (op[OP_LB])       r = 32'(b);
    else if (op[OP_LBU]) r = {24'h0, b};
    else if (op[OP_LH])  r = 32'(h);
    else if (op[OP_LHU]) r = {16'h0, h};
    else if (op[OP_LWL]) begin
      case (lane)
        2'd0: begin r = {d[7:0], 24'h0};  we = 4'h8; end
        2'd1: begin r = {d[15:0], 16'h0}; we = 4'hC; end
        2'd2: begin r = {d[23:0], 8'h0};  we = 4'hE; end
        2'd3: begin r = d;                we = 4'hF; end
      endcase
    end else if (op[OP_LWR]) begin
      case (lane)
        2'd0: begin r = d;                 we = 4'hF; end
        2'd1: begin r = {8'h0, d[31:8]};   we = 4'h7; end
        2'd2: begin r = {16'h0, d[31:16]}; we = 4'h3; end
        2'd3: begin r = {24'h0, d[31:24]}; we = 4'h1; end
      endcase
    end
    return {we, r};
  endfunction

  assign misalign = ((lq.req_op[OP_LH] | lq.req_op[OP_LHU]) & lq.req_addr[0]) |
                    (lq.req_op[OP_LW] & (lq.req_addr[1:0] != 2'b00));
  assign space     = count_q < DEPTH_C;
  assign head_live = (count_q != '0) & dvalid_q[head_q];

  assign lq.req_adel      = lq.req_valid & misalign;
  assign lq.req_ready     = ~rst & lq.mem_req_ready & space & ~lq.flush & ~lq.req_adel;
  assign lq.mem_req_valid = ~rst & lq.req_valid & ~lq.req_adel & space & ~lq.flush;
  assign lq.mem_req_addr  = {lq.req_addr[31:2], 2'b00};
  assign lq.wb_valid      = ~rst & head_live & ~kill_q[head_q];
  assign lq.wb_tag        = tag_q[head_q];
  assign {lq.wb_we, lq.wb_data} = align_word(op_q[head_q], off_q[head_q] ^ LANE_X,
                                             rfwr_q[head_q], data_q[head_q]);

  assign enq = lq.mem_req_valid & lq.mem_req_ready;
  assign ret = head_live & (kill_q[head_q] | lq.wb_ready);

  always_comb begin
    head_d  = ret ? head_q + PW'(1) : head_q;
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    fill_d  = lq.mem_resp_valid ? fill_q + PW'(1) : fill_q;
    count_d = count_q + CW'(enq) - CW'(ret);
  end

  // Control state: pointers, occupancy and per-entry status bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      dvalid_q <= '0;
      kill_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      // Killing every slot is safe: free slots clear kill when they are next enqueued.
      if (lq.flush) kill_q <= '1;
      if (lq.mem_resp_valid) dvalid_q[fill_q] <= 1'b1;
      if (enq) begin
        dvalid_q[tail_q] <= 1'b0;
        kill_q[tail_q]   <= 1'b0;
      end
      if (ret) begin
        dvalid_q[head_q] <= 1'b0;
        kill_q[head_q]   <= 1'b0;
      end
    end
  end

  // Payload storage: written on enqueue and on response, never reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      op_q[tail_q]   <= lq.req_op;
      off_q[tail_q]  <= lq.req_addr[1:0];
      tag_q[tail_q]  <= lq.req_tag;
      rfwr_q[tail_q] <= lq.req_rf_wr;
    end
    if (lq.mem_resp_valid) data_q[fill_q] <= lq.mem_resp_data;
  end
endmodule

// File: tb/tb_mem_load_queue.sv
// Bench for mem_load_queue: little- and big-endian instances driven identically and
// checked every cycle against one queue-level model, plus literal spot checks.
module tb_mem_load_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [6:0]       req_op = 7'h10;
  logic [31:0]      req_addr = 32'h0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             req_rf_wr = 1'b1;
  logic             mem_req_ready = 1'b1;
  logic             mem_resp_valid = 1'b0;
  logic [31:0]      mem_resp_data = 32'h0;
  logic             flush = 1'b0;
  logic             wb_ready = 1'b1;
  int               tests = 0;
  int               fails = 0;

  always #5 clk = ~clk;

  mem_load_queue_if #(.TAG_W(TAG_W)) bus_le ();
  mem_load_queue_if #(.TAG_W(TAG_W)) bus_be ();

  assign bus_le.req_valid = req_valid;           assign bus_be.req_valid = req_valid;
  assign bus_le.req_op = req_op;                 assign bus_be.req_op = req_op;
  assign bus_le.req_addr = req_addr;             assign bus_be.req_addr = req_addr;
  assign bus_le.req_tag = req_tag;               assign bus_be.req_tag = req_tag;
  assign bus_le.req_rf_wr = req_rf_wr;           assign bus_be.req_rf_wr = req_rf_wr;
  assign bus_le.mem_req_ready = mem_req_ready;   assign bus_be.mem_req_ready = mem_req_ready;
  assign bus_le.mem_resp_valid = mem_resp_valid; assign bus_be.mem_resp_valid = mem_resp_valid;
  assign bus_le.mem_resp_data = mem_resp_data;   assign bus_be.mem_resp_data = mem_resp_data;
  assign bus_le.flush = flush;                   assign bus_be.flush = flush;
  assign bus_le.wb_ready = wb_ready;             assign bus_be.wb_ready = wb_ready;

  mem_load_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .BIG_ENDIAN(0)) dut_le (.clk(clk), .rst(rst), .lq(bus_le));
  mem_load_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .BIG_ENDIAN(1)) dut_be (.clk(clk), .rst(rst), .lq(bus_be));

  // ---------------- behavioural model ----------------
  typedef struct {
    int               op;
    logic [1:0]       off;
    logic [TAG_W-1:0] tag;
    logic             rfw;
    logic [31:0]      d;
    bit               dv;
    bit               kill;
  } ent_t;
  ent_t mq[$];

  function automatic int op_idx(logic [6:0] op);
    for (int i = 0; i < 7; i++) if (op[i]) return i;
    return 7;
  endfunction

  function automatic bit e_adel();
    int k;
    k = op_idx(req_op);
    return req_valid && (((k == 2 || k == 3) && req_addr[0]) || (k == 4 && req_addr[1:0] != 2'b00));
  endfunction

  function automatic bit e_mrv();
    return !rst && req_valid && !e_adel() && mq.size() < DEPTH && !flush;
  endfunction

  function automatic bit e_ready();
    return !rst && mem_req_ready && mq.size() < DEPTH && !flush && !e_adel();
  endfunction

  function automatic bit e_wbv();
    return !rst && mq.size() > 0 && mq[0].dv && !mq[0].kill;
  endfunction

  function automatic int unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].dv) n++;
    return n;
  endfunction

  // Shift-based view of the load result: select/extend by byte offset arithmetic.
  function automatic logic [35:0] e_wb(ent_t e, bit be);
    int          lane, sh;
    logic [31:0] v;
    logic [3:0]  we;
    lane = int'(e.off) ^ (be ? 3 : 0);
    sh   = 8 * lane;
    we   = e.rfw ? 4'hF : 4'h0;
    case (e.op)
      0, 1: begin
        v = (e.d >> sh) & 32'hFF;
        if (e.op == 0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      2, 3: begin
        v = (lane >= 2) ? (e.d >> 16) : (e.d & 32'hFFFF);
        if (e.op == 2 && v[15]) v = v | 32'hFFFF_0000;
      end
      5: begin v = e.d << (8 * (3 - lane)); we = 4'(4'hF << (3 - lane)); end
      6: begin v = e.d >> sh;               we = 4'(4'hF >> lane); end
      default: v = e.d;
    endcase
    return {we, v};
  endfunction

  always @(posedge clk) begin : model
    bit   ret, enq;
    ent_t e;
    ret = mq.size() > 0 && mq[0].dv && (mq[0].kill || wb_ready);
    enq = e_mrv() && mem_req_ready;
    if (rst) mq.delete();
    else begin
      if (mem_resp_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].dv) begin
            e = mq[i]; e.d = mem_resp_data; e.dv = 1'b1; mq[i] = e;
            break;
          end
        end
      end
      if (flush) begin
        for (int i = 0; i < mq.size(); i++) begin
          e = mq[i]; e.kill = 1'b1; mq[i] = e;
        end
      end
      if (ret) void'(mq.pop_front());
      if (enq) begin
        e.op = op_idx(req_op); e.off = req_addr[1:0]; e.tag = req_tag;
        e.rfw = req_rf_wr; e.d = 32'h0; e.dv = 1'b0; e.kill = 1'b0;
        mq.push_back(e);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string p, bit be, logic rr, logic adel, logic mrv, logic [31:0] mra,
                         logic wbv, logic [TAG_W-1:0] tag, logic [3:0] we, logic [31:0] data);
    logic [35:0] x;
    chk({p, "req_ready"}, 32'(rr), 32'(e_ready()));
    chk({p, "req_adel"}, 32'(adel), 32'(e_adel()));
    chk({p, "mem_req_valid"}, 32'(mrv), 32'(e_mrv()));
    chk({p, "mem_req_addr"}, mra, {req_addr[31:2], 2'b00});
    chk({p, "wb_valid"}, 32'(wbv), 32'(e_wbv()));
    if (e_wbv()) begin
      x = e_wb(mq[0], be);
      chk({p, "wb_tag"}, 32'(tag), 32'(mq[0].tag));
      chk({p, "wb_we"}, 32'(we), 32'(x[35:32]));
      chk({p, "wb_data"}, data, x[31:0]);
    end
  endtask

  always @(negedge clk) begin
    cmp_dut("le.", 1'b0, bus_le.req_ready, bus_le.req_adel, bus_le.mem_req_valid, bus_le.mem_req_addr,
            bus_le.wb_valid, bus_le.wb_tag, bus_le.wb_we, bus_le.wb_data);
    cmp_dut("be.", 1'b1, bus_be.req_ready, bus_be.req_adel, bus_be.mem_req_valid, bus_be.mem_req_addr,
            bus_be.wb_valid, bus_be.wb_tag, bus_be.wb_we, bus_be.wb_data);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(int idx, logic [31:0] a, logic [TAG_W-1:0] t, logic rfw);
    req_valid = 1'b1; req_op = 7'(1 << idx); req_addr = a; req_tag = t; req_rf_wr = rfw;
  endtask

  // One load through an empty queue, with literal expectations for both endiannesses.
  task automatic single(int idx, logic [31:0] a, logic [TAG_W-1:0] t, logic rfw, logic [31:0] rd,
                        logic [31:0] le_d, logic [3:0] le_we, logic [31:0] be_d, logic [3:0] be_we, string nm);
    req(idx, a, t, rfw);
    cyc();
    req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = rd;
    cyc();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_vld"}, 32'(bus_le.wb_valid), 32'h1);
    chk({nm, "_tag"}, 32'(bus_le.wb_tag), 32'(t));
    chk({nm, "_le_data"}, bus_le.wb_data, le_d);
    chk({nm, "_le_we"}, 32'(bus_le.wb_we), 32'(le_we));
    chk({nm, "_be_data"}, bus_be.wb_data, be_d);
    chk({nm, "_be_we"}, 32'(bus_be.wb_we), 32'(be_we));
    cyc();
  endtask

  initial begin
    req(4, 32'h0, '0, 1'b1);
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus_le.req_ready), 32'h0);
    chk("rst_wb_valid", 32'(bus_le.wb_valid), 32'h0);
    chk("rst_mem_req_valid", 32'(bus_le.mem_req_valid), 32'h0);
    cyc();
    rst = 1'b0; req_valid = 1'b0;

    single(0, 32'h1003, 5'd3, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80, 4'hF, 32'h0000_0000, 4'hF, "lb");
    single(5, 32'h2001, 5'd4, 1'b1, 32'hAABB_CCDD, 32'hCCDD_0000, 4'hC, 32'hBBCC_DD00, 4'hE, "lwl");
    single(6, 32'h2002, 5'd5, 1'b1, 32'hAABB_CCDD, 32'h0000_AABB, 4'h3, 32'h00AA_BBCC, 4'h7, "lwr");
    single(4, 32'h6000, 5'd6, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'h0, 32'hCAFE_F00D, 4'h0, "lw_r0");

    // Misaligned requests are flagged and neither accepted nor issued.
    req(2, 32'h4001, 5'd1, 1'b1);
    @(negedge clk);
    chk("lh_adel", 32'(bus_le.req_adel), 32'h1);
    chk("lh_ready", 32'(bus_le.req_ready), 32'h0);
    chk("lh_mrv", 32'(bus_le.mem_req_valid), 32'h0);
    cyc();
    req(4, 32'h4002, 5'd1, 1'b1);
    @(negedge clk);
    chk("lw_adel", 32'(bus_be.req_adel), 32'h1);
    cyc();
    req_valid = 1'b0;
    single(3, 32'h4002, 5'd7, 1'b1, 32'h8001_0000, 32'h0000_8001, 4'hF, 32'h0000_0000, 4'hF, "lhu");

    // Fill the queue, then back-pressure the writeback port.
    for (int i = 0; i < DEPTH; i++) begin
      req(4, 32'h100 * i, TAG_W'(10 + i), 1'b1);
      @(negedge clk);
      chk("fill_ready", 32'(bus_le.req_ready), 32'h1);
      cyc();
    end
    req(4, 32'h900, 5'd14, 1'b1);
    @(negedge clk);
    chk("full_ready", 32'(bus_le.req_ready), 32'h0);
    chk("full_mrv", 32'(bus_le.mem_req_valid), 32'h0);
    cyc();
    req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_0000;
    cyc();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("full_wbv", 32'(bus_le.wb_valid), 32'h1);
    chk("full_tag", 32'(bus_le.wb_tag), 32'd10);
    chk("full_ready_hold", 32'(bus_le.req_ready), 32'h0);
    cyc();
    @(negedge clk);
    chk("freed_ready", 32'(bus_le.req_ready), 32'h1);
    cyc();
    wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'h2222_0000 + k;
      cyc();
    end
    mem_resp_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("bp_wbv", 32'(bus_le.wb_valid), 32'h1);
    chk("bp_tag", 32'(bus_le.wb_tag), 32'd11);
    chk("bp_data", bus_le.wb_data, 32'h2222_0000);
    cyc();
    @(negedge clk);
    chk("bp_tag_stable", 32'(bus_le.wb_tag), 32'd11);
    cyc();
    wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain_wbv", 32'(bus_le.wb_valid), 32'h1);
      chk("drain_tag", 32'(bus_le.wb_tag), 32'(11 + k));
      chk("drain_data", bus_le.wb_data, 32'h2222_0000 + k);
      cyc();
    end
    @(negedge clk);
    chk("drain_done", 32'(bus_le.wb_valid), 32'h0);
    cyc();

    // Flush with three loads outstanding; the first response lands in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      req(4, 32'h500 + 4 * i, TAG_W'(20 + i), 1'b1);
      cyc();
    end
    req(4, 32'h700, 5'd29, 1'b1);
    flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_0000;
    @(negedge clk);
    chk("fl_ready", 32'(bus_le.req_ready), 32'h0);
    chk("fl_mrv", 32'(bus_le.mem_req_valid), 32'h0);
    cyc();
    flush = 1'b0; req_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      mem_resp_valid = (k < 3); mem_resp_data = 32'hBEEF_0000 + k;
      @(negedge clk);
      chk("fl_no_wb", 32'(bus_le.wb_valid), 32'h0);
      cyc();
    end
    mem_resp_valid = 1'b0;
    cyc();
    single(4, 32'h3000, 5'd25, 1'b1, 32'h1234_5678, 32'h1234_5678, 4'hF, 32'h1234_5678, 4'hF, "post_flush");

    // Random traffic with one mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      rst            = (i == 2000 || i == 2001);
      req_valid      = ($urandom_range(0, 3) != 0);
      req_op         = 7'(1 << $urandom_range(0, 6));
      req_addr       = $urandom;
      req_tag        = TAG_W'($urandom);
      req_rf_wr      = 1'($urandom_range(0, 1));
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      wb_ready       = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 49) == 0);
      mem_resp_valid = !rst && unfilled() > 0 && ($urandom_range(0, 1) == 1);
      mem_resp_data  = $urandom;
      cyc();
    end
    rst = 1'b0; req_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1; mem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_resp_valid = unfilled() > 0;
      mem_resp_data  = $urandom;
      cyc();
    end
    mem_resp_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("end_wbv", 32'(bus_le.wb_valid), 32'h0);
    chk("end_ready", 32'(bus_le.req_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
